adam_aes_decipher_iterative: RTL
================================

Name: adam_aes_decipher_iterative

Overview:
Iterative AES inverse cipher for the adam AES peripheral. It is the decrypt counterpart to the pipelined encipher and is driven by the core FSM when encdec=0. It executes one inverse round per clock from precomputed round keys supplied by the key expansion block. It supports 128-bit (10 rounds) and 256-bit (14 rounds) keys.

Parameters:
NUM_RK, 15, number of 128-bit round keys on round_keys; fixed at 15 (only legal value).

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request to decrypt block; accepted only when ready=1
keylen  input  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled on accepted start
block  input  128  ciphertext; sampled on accepted start
round_keys  input  1920  rk[i] = bits [128*i+127 : 128*i]; encryption-order keys, rk[0] = first key
ready  output  1  high when idle and able to accept start
valid  output  1  one-cycle pulse, result updated
result  output  128  plaintext; held until the next completion

Behaviour:
- Clock and reset: clk rising edge; reset_n asynchronous, active-low.
- Reset values: ready=1, valid=0, result=0, state=IDLE, round_ctr=0, state register=0.
- States: IDLE, ROUND.
- IDLE:
  - ready=1.
  - On start: latch keylen into nr_reg (10 or 14).
  - state_reg <= block ^ rk[Nr]; round_ctr <= Nr-1; go to ROUND; ready <= 0.
- ROUND with round_ctr >= 1:
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk[round_ctr]).
  - round_ctr decrements.
- ROUND with round_ctr == 0 (final round, no InvMixColumns):
  - result <= InvSubBytes(InvShiftRows(state_reg)) ^ rk[0].
  - valid <= 1 for one cycle; ready <= 1; go to IDLE.
- Latency: start sampled at edge E0; valid=1 in the cycle after edge E(Nr).
  - AES-128: valid appears 10 cycles after the start cycle.
  - AES-256: valid appears 14 cycles after the start cycle.
- Throughput: one block per Nr+1 cycles; back-to-back is allowed because ready=1 in the valid cycle, so start is accepted then.
- Handshake edge cases:
  - start while ready=0 is ignored entirely; no queuing, no effect on the block in flight.
  - keylen and block changes after an accepted start have no effect.
  - round_keys is not latched. The core holds it stable from start to valid; the block does not check this.
- Arithmetic:
  - InvShiftRows: row r rotated right by r bytes; FIPS-197 column-major byte order, byte 0 = bits [127:120].
  - InvSubBytes: full 256-entry inverse S-box, combinational; 16 instances.
  - InvMixColumns: GF(2^8) multiplication by 0e/0b/0d/09, reduction polynomial 0x11B.
- Reset mid-operation: the operation is aborted with no valid pulse and result returns to 0. ready=1 after reset release.
- valid never asserts except as the completion pulse; valid and ready are never both low-to-high glitched within a cycle (registered outputs only).

Optional Feature:
Macro ADAM_AES_DEC_OUT_REG_EN.
- Defined: result and valid pass through one extra register stage. Latency becomes Nr+1 cycles. ready still rises at edge E(Nr), so a new start may overlap the output stage. The output register resets to 0.
- Undefined: timing is as stated in Behaviour.

Test Plan:
1. AES-128 (FIPS-197 C.1): key 000102030405060708090a0b0c0d0e0f, bench-expanded rk[0..10], keylen=0, block=69c4e0d86a7b0430d8cdb78070b4c55a -> valid 10 cycles after start, result=00112233445566778899aabbccddeeff, ready low exactly during the 10 busy cycles.
2. AES-256 (FIPS-197 C.3): key 000102...1f, rk[0..14], keylen=1, block=8ea2b7ca516745bfeafc49904b496089 -> valid after 14 cycles, result=00112233445566778899aabbccddeeff.
3. Back-to-back: assert start in the valid cycle of test 1 with block=69c4e0d86a7b0430d8cdb78070b4c55a and keylen=1 set simultaneously -> second op runs 14 rounds; first result is unchanged until the second valid.
4. Busy start: pulse start and change block to all-ones at cycle 3 of an AES-128 op -> ignored; the correct test-1 plaintext appears at cycle 10 and exactly one valid pulse occurs.
5. Reset mid-op: assert reset_n=0 at round 5 -> ready=1, valid=0, result=0 immediately; no valid after release; a fresh test-1 op then passes.
6. Random regression: 1000 random key/block pairs for both keylens, compared against a C reference model -> zero mismatches. Repeat with ADAM_AES_DEC_OUT_REG_EN defined, expecting latency +1.

Source files
------------

// File: rtl/adam_aes_decipher_iterative.sv
// adam_aes_decipher_iterative: iterative AES-128/256 inverse cipher, one inverse round per clock.
// Define ADAM_AES_DEC_OUT_REG_EN to add one register stage on result/valid.
module adam_aes_decipher_iterative #(
   parameter int NUM_RK = 15
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    keylen,
   input  logic [127:0]            block,
   input  logic [128*NUM_RK-1:0]   round_keys,
   output logic                    ready,
   output logic                    valid,
   output logic [127:0]            result
);
   localparam logic [2047:0] inv_sbox = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
   typedef enum logic {IDLE, ROUND} state_e;
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   // constant multiply built from the xtime chain; k selects 1/2/4/8 terms
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] a2, a4, a8;
      a2 = xt(a);
      a4 = xt(a2);
      a8 = xt(a4);
      return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
   endfunction
   // byte n sits at row n%4, column n/4; row r reads from column c-r
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   b;
      int           src;
      for (int n = 0; n < 16; n++) begin
         src = 4 * (((n / 4) + 4 - (n % 4)) % 4) + (n % 4);
         b = s[127-8*src -: 8];
         o[127-8*n -: 8] = inv_sbox[2047-8*int'(b) -: 8];
      end
      return o;
   endfunction
   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = gm(s[127-8*(4*c+r) -: 8], 4'he)
                                  ^ gm(s[127-8*(4*c+(r+1)%4) -: 8], 4'hb)
                                  ^ gm(s[127-8*(4*c+(r+2)%4) -: 8], 4'hd)
                                  ^ gm(s[127-8*(4*c+(r+3)%4) -: 8], 4'h9);
      return o;
   endfunction
   state_e        state_q, state_d;
   logic [3:0]    round_ctr_q, round_ctr_d;
   logic [127:0]  st_q, st_d, res_q, res_d, rk, isb;
   logic          ready_q, ready_d, valid_q, valid_d;
   always_comb begin
      rk          = round_keys[128*round_ctr_q +: 128];
      isb         = inv_shift_sub(st_q) ^ rk;
      state_d     = state_q;
      round_ctr_d = round_ctr_q;
      st_d        = st_q;
      res_d       = res_q;
      ready_d     = ready_q;
      valid_d     = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            st_d        = block ^ round_keys[(keylen ? 1792 : 1280) +: 128];
            round_ctr_d = keylen ? 4'd13 : 4'd9;
            state_d     = ROUND;
            ready_d     = 1'b0;
         end
      end else if (round_ctr_q != 4'd0) begin
         st_d        = inv_mix(isb);
         round_ctr_d = round_ctr_q - 4'd1;
      end else begin
         res_d   = isb;
         valid_d = 1'b1;
         ready_d = 1'b1;
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         round_ctr_q <= 4'd0;
         st_q        <= '0;
         res_q       <= '0;
         ready_q     <= 1'b1;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_ctr_q <= round_ctr_d;
         st_q        <= st_d;
         res_q       <= res_d;
         ready_q     <= ready_d;
         valid_q     <= valid_d;
      end
   end
   assign ready = ready_q;
`ifdef ADAM_AES_DEC_OUT_REG_EN
   logic [127:0] res_out_q;
   logic         valid_out_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_out_q   <= '0;
         valid_out_q <= 1'b0;
      end else begin
         res_out_q   <= res_q;
         valid_out_q <= valid_q;
      end
   end
   assign result = res_out_q;
   assign valid  = valid_out_q;
`else
   assign result = res_q;
   assign valid  = valid_q;
`endif
endmodule
